instr_prefetch_buffer: RTL and testbench
========================================

// Module: instr_prefetch_buffer
// PURPOSE
//  Initiator side of the instruction RAM port; drives the en/addr/we/be/wdata/rdata interface of the RAM wrapper.
//  Issues sequential word reads, buffers returned words with their addresses in a small FIFO, presents them to
//  the core via valid/ready. Sits between core IF stage and instruction RAM wrapper (boot ROM = top address bit).
// PARAMETERS
//  ADDR_WIDTH  16      byte-address width of RAM port (MSB=1 selects boot ROM)
//  DATA_WIDTH  32      word width; address step = DATA_WIDTH/8
//  FIFO_DEPTH  4       buffered words, power of two, >=2
//  BOOT_ADDR   16'h8000  first fetch address after reset
// PORTS
//  clk            in   1           clock
//  rst_n          in   1           async reset, active low
//  fetch_en_i     in   1           permit new read requests
//  branch_i       in   1           redirect fetch, flush buffer (single-cycle pulse)
//  branch_addr_i  in   ADDR_WIDTH  redirect target; bits [1:0] ignored, forced 0
//  instr_valid_o  out  1           FIFO head valid
//  instr_ready_i  in   1           core accepts head
//  instr_rdata_o  out  DATA_WIDTH  head instruction word
//  instr_addr_o   out  ADDR_WIDTH  byte address of head word
//  mem_en_o       out  1           RAM request (read)
//  mem_addr_o     out  ADDR_WIDTH  RAM byte address
//  mem_we_o       out  1           constant 0
//  mem_be_o       out  DATA_WIDTH/8 constant all-ones
//  mem_wdata_o    out  DATA_WIDTH  constant 0
//  mem_rdata_i    in   DATA_WIDTH  RAM read data, valid exactly 1 cycle after mem_en_o
// BEHAVIOUR
//  Reset: instr_valid_o=0, instr_rdata_o=0, instr_addr_o=0, mem_en_o=0, mem_addr_o=0; FIFO empty, pending=0,
//   fetch pointer=BOOT_ADDR. Async reset mid-operation discards in-flight return.
//  RAM: fixed 1-cycle latency, no stall; at most 1 request in flight (pending flag + pending address reg).
//  Issue: mem_en_o=1 when fetch_en_i && (count+pending) < FIFO_DEPTH, or when branch_i && fetch_en_i.
//   mem_addr_o = branch_i ? {branch_addr_i[AW-1:2],2'b00} : fetch pointer. On issue pointer <= mem_addr_o+4.
//   Pointer wraps modulo 2^ADDR_WIDTH (0xFFFC -> 0x0000). Credit check excludes same-cycle pop (conservative).
//  Return: cycle after issue, {mem_rdata_i, pending addr} pushed into FIFO; pending cleared unless new issue.
//   Overflow impossible by credit rule; push and pop in same cycle allowed, count unchanged.
//  Output: head drives instr_rdata_o/instr_addr_o; pop on instr_valid_o && instr_ready_i. Data stable while
//   valid && !ready. Empty: instr_valid_o=0, rdata/addr hold last value.
//  Branch cycle: FIFO flushed (count<=0), return arriving this cycle discarded, instr_valid_o forced 0 and
//   instr_ready_i ignored; request to target issued same cycle if fetch_en_i (zero-bubble redirect).
//   branch_i with fetch_en_i=0: pointer <= target, no request, pending cleared.
//  fetch_en_i low: no new requests; an outstanding return is still pushed and delivered.
//  Throughput: ready held high -> one instruction per cycle; first word valid 2 cycles after first issue cycle
//   (issue c0, push c1, valid c1 registered -> visible c2).
// TESTING
//  1 Reset, fetch_en_i=1, ready=1 -> mem_addr 0x8000,0x8004,0x8008..; instr_addr_o 0x8000 valid at c2, then 1/cycle.
//  2 ready=0 from start -> exactly 4 mem_en_o pulses (0x8000..0x800C) then idle; release ready -> 4 words in order.
//  3 FIFO holds 3, branch_i to 0x0102 -> valid=0 that cycle, mem_addr=0x0100 same cycle, next head addr 0x0100, no stale word.
//  4 branch_i to 0xFFFC, ready=1 -> fetch sequence 0xFFFC,0x0000,0x0004.
//  5 fetch_en_i dropped cycle after an issue -> that word still delivered, mem_en_o stays 0 afterwards.
//  6 rst_n low mid-stream -> outputs 0 asynchronously; after release restart at 0x8000, no pre-reset data.

Source files
------------

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher: issues single-word reads to the instruction RAM port
// (1-cycle latency, one request in flight) and queues {word, address} pairs for the core.
module instr_prefetch_buffer #(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = 16'h8000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fetch_en_i,
  input  logic                    branch_i,
  input  logic [ADDR_WIDTH-1:0]   branch_addr_i,
  output logic                    instr_valid_o,
  input  logic                    instr_ready_i,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  output logic [ADDR_WIDTH-1:0]   instr_addr_o,
  output logic                    mem_en_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int unsigned BW = DATA_WIDTH / 8;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;
  logic                  pending;
  logic [ADDR_WIDTH-1:0] pending_addr, fetch_ptr, last_addr;
  logic [DATA_WIDTH-1:0] last_data;

  logic                  issue, push, pop, empty;
  logic [ADDR_WIDTH-1:0] target, req_addr;
  logic [CW:0]           used;

  always_comb begin
    target   = branch_addr_i & ~ADDR_WIDTH'(BW - 1);
    req_addr = branch_i ? target : fetch_ptr;
    // Credit counts the in-flight word but not a same-cycle pop.
    used     = {1'b0, count} + {{CW{1'b0}}, pending};
    issue    = rst_n && fetch_en_i && (branch_i || (used < (CW+1)'(FIFO_DEPTH)));
    empty    = (count == '0);
    push     = pending && !branch_i;
    pop      = !empty && instr_ready_i && !branch_i;
  end

  assign mem_en_o      = issue;
  assign mem_addr_o    = issue ? req_addr : '0;
  assign mem_we_o      = 1'b0;
  assign mem_be_o      = '1;
  assign mem_wdata_o   = '0;
  assign instr_valid_o = !empty && !branch_i;
  assign instr_rdata_o = empty ? last_data : fifo_data[rd_ptr];
  assign instr_addr_o  = empty ? last_addr : fifo_addr[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= mem_rdata_i;
      fifo_addr[wr_ptr] <= pending_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      pending      <= 1'b0;
      pending_addr <= '0;
      fetch_ptr    <= BOOT_ADDR;
      last_data    <= '0;
      last_addr    <= '0;
    end else begin
      if (!empty) begin
        last_data <= fifo_data[rd_ptr];
        last_addr <= fifo_addr[rd_ptr];
      end
      if (branch_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
      pending <= issue;
      if (issue) begin
        pending_addr <= req_addr;
        fetch_ptr    <= req_addr + ADDR_WIDTH'(BW);
      end else if (branch_i) begin
        fetch_ptr <= target;
      end
    end
  end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Bench for instr_prefetch_buffer: RAM model with 1-cycle read latency, queue-based reference
// model, table-driven vectors, hand-written corner sequences and a randomized run.
module tb_instr_prefetch_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        branch = 1'b0;
  logic [15:0] branch_addr = '0;
  logic        ready = 1'b0;
  logic        instr_valid;
  logic [31:0] instr_rdata;
  logic [15:0] instr_addr;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  instr_prefetch_buffer #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .FIFO_DEPTH(4), .BOOT_ADDR(16'h8000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en_i(fetch_en), .branch_i(branch),
    .branch_addr_i(branch_addr), .instr_valid_o(instr_valid), .instr_ready_i(ready),
    .instr_rdata_o(instr_rdata), .instr_addr_o(instr_addr), .mem_en_o(mem_en),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [15:0] a);
    return {~a, a} ^ 32'h0F0F_3C3C;
  endfunction

  // RAM: data for the requested address is presented the cycle after the request.
  always @(posedge clk) mem_rdata <= mem_en ? word_of(mem_addr) : 32'hDEAD_BEEF;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of delivered words plus the fetch pointer and in-flight request.
  typedef struct { logic [15:0] a; logic [31:0] d; } ent_t;
  ent_t        q[$];
  logic [15:0] m_ptr, m_pend_addr, m_last_a;
  logic [31:0] m_last_d;
  logic        m_pend;

  task automatic model_reset();
    q.delete();
    m_ptr = 16'h8000; m_pend = 1'b0; m_pend_addr = '0;
    m_last_a = '0; m_last_d = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; fetch_en = 1'b0; branch = 1'b0; branch_addr = '0; ready = 1'b0;
    #1;
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_mem_en", {31'b0, mem_en}, 32'd0);
    check("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
    check("rst_rdata", instr_rdata, 32'd0);
    check("rst_iaddr", {16'b0, instr_addr}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // One clock cycle: drive inputs after the edge, compare at the falling edge, advance the model.
  task automatic step(input logic fe, input logic br, input logic [15:0] ba, input logic rdy);
    logic        e_valid, e_en;
    logic [15:0] e_maddr, tgt, h_a;
    logic [31:0] h_d;
    @(posedge clk);
    #1 fetch_en = fe; branch = br; branch_addr = ba; ready = rdy;
    @(negedge clk);
    tgt     = ba & 16'hFFFC;
    e_valid = (q.size() != 0) && !br;
    e_en    = fe && (br || ((q.size() + int'(m_pend)) < 4));
    e_maddr = e_en ? (br ? tgt : m_ptr) : 16'h0000;
    h_a     = (q.size() != 0) ? q[0].a : m_last_a;
    h_d     = (q.size() != 0) ? q[0].d : m_last_d;
    check("mdl_valid", {31'b0, instr_valid}, {31'b0, e_valid});
    check("mdl_mem_en", {31'b0, mem_en}, {31'b0, e_en});
    check("mdl_mem_addr", {16'b0, mem_addr}, {16'b0, e_maddr});
    check("mdl_iaddr", {16'b0, instr_addr}, {16'b0, h_a});
    check("mdl_rdata", instr_rdata, h_d);
    check("mem_const", {mem_we, mem_be, mem_wdata[26:0]}, {1'b0, 4'hF, 27'd0});
    if (q.size() != 0) begin m_last_a = q[0].a; m_last_d = q[0].d; end
    if (br) q.delete();
    else begin
      if (e_valid && rdy) void'(q.pop_front());
      if (m_pend) q.push_back('{m_pend_addr, word_of(m_pend_addr)});
    end
    m_pend = e_en;
    if (e_en) begin m_pend_addr = e_maddr; m_ptr = e_maddr + 16'd4; end
    else if (br) m_ptr = tgt;
  endtask

  typedef struct {
    logic fe, br, rdy; logic [15:0] ba;
    logic en; logic [15:0] maddr; logic valid; logic [15:0] iaddr;
  } vec_t;
  vec_t vt[9];

  initial begin
    int n, got;
    logic seen;
    model_reset();
    do_reset();

    // Sequential stream from boot address, then a redirect that wraps the address space.
    vt[0] = '{1, 0, 1, 16'h0000, 1, 16'h8000, 0, 16'h0000};
    vt[1] = '{1, 0, 1, 16'h0000, 1, 16'h8004, 0, 16'h0000};
    vt[2] = '{1, 0, 1, 16'h0000, 1, 16'h8008, 1, 16'h8000};
    vt[3] = '{1, 0, 1, 16'h0000, 1, 16'h800C, 1, 16'h8004};
    vt[4] = '{1, 0, 1, 16'h0000, 1, 16'h8010, 1, 16'h8008};
    vt[5] = '{1, 1, 1, 16'hFFFE, 1, 16'hFFFC, 0, 16'h0000};
    vt[6] = '{1, 0, 1, 16'h0000, 1, 16'h0000, 0, 16'h0000};
    vt[7] = '{1, 0, 1, 16'h0000, 1, 16'h0004, 1, 16'hFFFC};
    vt[8] = '{1, 0, 1, 16'h0000, 1, 16'h0008, 1, 16'h0000};
    for (int i = 0; i < 9; i++) begin
      step(vt[i].fe, vt[i].br, vt[i].ba, vt[i].rdy);
      check($sformatf("vec%0d_en", i), {31'b0, mem_en}, {31'b0, vt[i].en});
      check($sformatf("vec%0d_maddr", i), {16'b0, mem_addr}, {16'b0, vt[i].maddr});
      check($sformatf("vec%0d_valid", i), {31'b0, instr_valid}, {31'b0, vt[i].valid});
      if (vt[i].valid) check($sformatf("vec%0d_iaddr", i), {16'b0, instr_addr}, {16'b0, vt[i].iaddr});
    end

    // Stalled core: credit limit stops issue at four words, then they drain in order.
    do_reset();
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 16'h0, 0);
      if (mem_en) begin
        check("stall_addr", {16'b0, mem_addr}, 32'h8000 + 32'(4 * n));
        n++;
      end
    end
    check("stall_pulses", n, 4);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 16'h0, 1);
      check("drain_valid", {31'b0, instr_valid}, 32'd1);
      check("drain_addr", {16'b0, instr_addr}, 32'h8000 + 32'(4 * i));
      check("drain_data", instr_rdata, word_of(16'h8000 + 16'(4 * i)));
    end
    step(0, 0, 16'h0, 1);
    check("drain_empty", {31'b0, instr_valid}, 32'd0);

    // Branch with three buffered words: no stale word may follow.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 16'h0, 0);
    step(0, 0, 16'h0, 0);
    step(0, 0, 16'h0, 0);
    check("pre_br_valid", {31'b0, instr_valid}, 32'd1);
    step(1, 1, 16'h0102, 1);
    check("br_valid", {31'b0, instr_valid}, 32'd0);
    check("br_mem_en", {31'b0, mem_en}, 32'd1);
    check("br_mem_addr", {16'b0, mem_addr}, 32'h0100);
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      step(1, 0, 16'h0, 1);
      if (instr_valid) begin
        seen = 1'b1;
        check("br_head_addr", {16'b0, instr_addr}, 32'h0100);
      end
    end
    check("br_head_seen", {31'b0, seen}, 32'd1);

    // Fetch disabled right after an issue: the outstanding word is still delivered.
    do_reset();
    step(1, 0, 16'h0, 1);
    got = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 16'h0, 1);
      check("fe_off_mem_en", {31'b0, mem_en}, 32'd0);
      if (instr_valid) begin
        got++;
        check("fe_off_addr", {16'b0, instr_addr}, 32'h8000);
      end
    end
    check("fe_off_count", got, 1);

    // Asynchronous reset in the middle of a stream.
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 0, 16'h0, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", {31'b0, instr_valid}, 32'd0);
    check("async_mem_en", {31'b0, mem_en}, 32'd0);
    check("async_mem_addr", {16'b0, mem_addr}, 32'd0);
    check("async_iaddr", {16'b0, instr_addr}, 32'd0);
    check("async_rdata", instr_rdata, 32'd0);
    do_reset();
    step(1, 0, 16'h0, 1);
    check("restart_addr", {16'b0, mem_addr}, 32'h8000);
    step(1, 0, 16'h0, 1);
    check("restart_no_old", {31'b0, instr_valid}, 32'd0);
    step(1, 0, 16'h0, 1);
    check("restart_head", {16'b0, instr_addr}, 32'h8000);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
           16'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
